// File: rtl/id_pkg.sv
// id_pkg: shared encodings, ALU control codes and control bundle for the decode stage.
package id_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b1111;
  typedef enum logic [2:0] {K_BAD, K_R, K_LW, K_SW, K_ADDI, K_BEQ, K_BNE, K_J} kind_e;
  typedef struct packed {
    logic       valid;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  // returns {known, alu_ctrl}
  function automatic logic [4:0] funct_alu(input logic [5:0] f);
    return f == FN_ADD ? {1'b1, ALU_ADD} :
           f == FN_SUB ? {1'b1, ALU_SUB} :
           f == FN_DIV ? {1'b1, ALU_DIV} :
           f == FN_OR  ? {1'b1, ALU_OR}  :
           f == FN_XOR ? {1'b1, ALU_XOR} :
           f == FN_AND ? {1'b1, ALU_AND} : 5'b0;
  endfunction
endpackage

// File: rtl/id_regfile.sv
// id_regfile: NREG x XLEN register file, two read ports, one write port with write-through.
module id_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int ZERO_REG = 1,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [RW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [RW-1:0]   i_ra1,
  input  logic [RW-1:0]   i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);
  logic [XLEN-1:0] r_mem [NREG];
  logic w_we;
  assign w_we = i_we && !(ZERO_REG != 0 && i_wa == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    else if (w_we)
      r_mem[i_wa] <= i_wd;
  assign o_rd1 = (w_we && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
  assign o_rd2 = (w_we && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];
endmodule

// File: rtl/id_stage_p.sv
// id_stage_p: decode stage with operand forwarding, load-use/branch hazard stalls,
// in-ID branch resolution and a registered ID/EX bundle.
module id_stage_p
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int ZERO_REG = 1,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc4,
  output logic            id_ready,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_reg,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_memread,
  input  logic [RW-1:0]   ex_dest,
  input  logic            ex_regwrite,
  input  logic            mem_fwd_we,
  input  logic [RW-1:0]   mem_fwd_reg,
  input  logic [XLEN-1:0] mem_fwd_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            idex_valid,
  output logic [3:0]      idex_alu_ctrl,
  output logic            idex_alu_src,
  output logic            idex_memread,
  output logic            idex_memwrite,
  output logic            idex_memtoreg,
  output logic            idex_regwrite,
  output logic [RW-1:0]   idex_dest,
  output logic [XLEN-1:0] idex_rd1,
  output logic [XLEN-1:0] idex_rd2,
  output logic [XLEN-1:0] idex_imm,
  output logic            illegal
);
  logic [5:0] w_op, w_fn;
  logic [RW-1:0] w_rs, w_rt, w_rd;
  logic w_fn_ok, w_uses_rs, w_uses_rt, w_is_br, w_hit, w_stall, w_issue, w_taken;
  logic [3:0] w_fn_alu;
  kind_e w_kind;
  ctrl_t w_ctrl, r_ctrl;
  logic [XLEN-1:0] w_rf1, w_rf2, w_a, w_b, w_sext;
  logic [RW-1:0] r_dest;
  logic [XLEN-1:0] r_rd1, r_rd2, r_imm;
  logic r_illegal, r_br_ld;
  logic w_unused;
  assign w_op = if_instr[31:26];
  assign w_fn = if_instr[5:0];
  assign w_rs = if_instr[21 +: RW];
  assign w_rt = if_instr[16 +: RW];
  assign w_rd = if_instr[11 +: RW];
  assign w_unused = ^if_instr[25:6];
  assign {w_fn_ok, w_fn_alu} = funct_alu(w_fn);
  assign w_kind = w_op == OP_R    ? (w_fn_ok ? K_R : K_BAD) :
                  w_op == OP_LW   ? K_LW   :
                  w_op == OP_SW   ? K_SW   :
                  w_op == OP_ADDI ? K_ADDI :
                  w_op == OP_BEQ  ? K_BEQ  :
                  w_op == OP_BNE  ? K_BNE  :
                  w_op == OP_J    ? K_J    : K_BAD;
  assign w_is_br   = w_kind == K_BEQ || w_kind == K_BNE;
  assign w_uses_rs = w_kind != K_BAD && w_kind != K_J;
  assign w_uses_rt = w_kind == K_R || w_kind == K_SW || w_is_br;
  assign w_ctrl = '{
    valid:    w_kind inside {K_R, K_LW, K_SW, K_ADDI},
    alu_ctrl: w_kind == K_R ? w_fn_alu : ALU_ADD,
    alu_src:  w_kind inside {K_LW, K_SW, K_ADDI},
    memread:  w_kind == K_LW,
    memwrite: w_kind == K_SW,
    memtoreg: w_kind == K_LW,
    regwrite: w_kind inside {K_R, K_LW, K_ADDI}
  };
  id_regfile #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(ZERO_REG)) u_rf (
    .clk(clk), .rst_n(rst_n), .i_we(wb_we), .i_wa(wb_reg), .i_wd(wb_data),
    .i_ra1(w_rs), .i_ra2(w_rt), .o_rd1(w_rf1), .o_rd2(w_rf2)
  );
  // MEM forwarding beats the regfile path, which already covers WB write-through
  function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] r, input logic [XLEN-1:0] rf);
    return (ZERO_REG != 0 && r == '0) ? '0 :
           (mem_fwd_we && mem_fwd_reg == r) ? mem_fwd_data : rf;
  endfunction
  assign w_a = fwd(w_rs, w_rf1);
  assign w_b = fwd(w_rt, w_rf2);
  assign w_hit = ex_dest != '0 && ((w_uses_rs && ex_dest == w_rs) || (w_uses_rt && ex_dest == w_rt));
  // r_br_ld adds the second stall cycle while a load feeding a branch sits in MEM
  assign w_stall = if_valid && (r_br_ld || (w_hit && (ex_memread || (w_is_br && ex_regwrite))));
  assign id_ready = !w_stall;
  assign w_issue = if_valid && !w_stall && w_ctrl.valid;
  assign w_sext = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
  assign w_taken = (w_kind == K_BEQ && w_a == w_b) || (w_kind == K_BNE && w_a != w_b);
  assign redirect = if_valid && !w_stall && (w_taken || w_kind == K_J);
  assign redirect_pc = w_kind == K_J ? {if_pc4[XLEN-1:28], if_instr[25:0], 2'b00} : if_pc4 + (w_sext << 2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ctrl <= CTRL_NOP;
      r_dest <= '0;
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_imm <= '0;
      r_illegal <= 1'b0;
      r_br_ld <= 1'b0;
    end else begin
      r_ctrl <= w_issue ? w_ctrl : CTRL_NOP;
      r_dest <= w_issue ? (w_kind == K_R ? w_rd : w_rt) : '0;
      r_rd1 <= w_a;
      r_rd2 <= w_b;
      r_imm <= w_sext;
      r_illegal <= if_valid && w_kind == K_BAD && if_instr != '0;
      r_br_ld <= if_valid && w_is_br && ex_memread && w_hit;
    end
  assign idex_valid    = r_ctrl.valid;
  assign idex_alu_ctrl = r_ctrl.alu_ctrl;
  assign idex_alu_src  = r_ctrl.alu_src;
  assign idex_memread  = r_ctrl.memread;
  assign idex_memwrite = r_ctrl.memwrite;
  assign idex_memtoreg = r_ctrl.memtoreg;
  assign idex_regwrite = r_ctrl.regwrite;
  assign idex_dest     = r_dest;
  assign idex_rd1      = r_rd1;
  assign idex_rd2      = r_rd2;
  assign idex_imm      = r_imm;
  assign illegal       = r_illegal;
endmodule

// File: doc/id_stage_p.md
ID_STAGE_P -- requirements
Module: id_stage_p

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREG, default 32, architectural register count, power of two; RW = log2(NREG).
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 if_valid / if_instr / if_pc4  in  1 / 32 / XLEN  fetched instruction and its PC+4.
REQ-007 id_ready  out  1  ID accepts if_* this cycle; low = IF holds.
REQ-008 wb_we / wb_reg / wb_data  in  1 / RW / XLEN  writeback port.
REQ-009 ex_memread / ex_dest / ex_regwrite  in  1 / RW / 1  state of instruction now in EX.
REQ-010 mem_fwd_we / mem_fwd_reg / mem_fwd_data  in  1 / RW / XLEN  ALU result held in MEM.
REQ-011 redirect / redirect_pc  out  1 / XLEN  taken jump/branch; IF loads redirect_pc and squashes its slot.
REQ-012 idex_valid, idex_alu_ctrl[3:0], idex_alu_src, idex_memread, idex_memwrite, idex_memtoreg, idex_regwrite, idex_dest[RW], idex_rd1, idex_rd2, idex_imm[XLEN]  out  registered ID/EX bundle.
REQ-013 illegal  out  1  registered, one-cycle pulse for an undecodable valid instruction.

Function
REQ-014 Decode opcode/funct: R-type funct add 100000->0010, sub 100010->0110, 011010->0101, or 100101->0001, xor 100110->1111, and 100100->0000; lw 100011, sw 101011, addi 001000 -> 0010; beq 000100, bne 000101; j 000010.
REQ-015 Unknown opcode or R-type funct, or all-zero word, SHALL produce a bubble (idex_valid=0, all control 0); unknown encodings also pulse illegal.
REQ-016 Register file NREG x XLEN, written on rising edge when wb_we; same-cycle read of wb_reg SHALL return wb_data (write-through).
REQ-017 Operand source priority: mem_fwd (mem_fwd_we, reg match) > wb write-through > register file; register 0 always zero when ZERO_REG=1.
REQ-018 Load-use stall: ex_memread and ex_dest!=0 matching rs, or rt for R-type/sw/beq/bne -> id_ready=0, bubble into ID/EX, instruction held one cycle.
REQ-019 Branch stall: beq/bne with ex_regwrite and ex_dest!=0 matching rs or rt -> same stall; a load feeding a branch stalls two cycles total.
REQ-020 Branch compare uses forwarded operands; beq taken when equal, bne when unequal.
REQ-021 Branch target = if_pc4 + (sext(imm16) << 2), modulo 2^XLEN; jump target = {if_pc4[XLEN-1:28], instr[25:0], 2'b00}.
REQ-022 redirect is combinational from the accepted instruction, asserted only when if_valid and not stalled; branches/jumps enter ID/EX as bubbles.
REQ-023 idex_dest = rd for R-type, rt otherwise; idex_imm = sext(imm16); idex_rd2 carries rt value (store data), ALU mux in EX selects via idex_alu_src.
REQ-024 if_valid=0 -> bubble into ID/EX, id_ready=1, no redirect.

Reset
REQ-025 rst_n low SHALL immediately clear all idex_* outputs, illegal, and every register file entry to 0.
REQ-026 Reset mid-stall SHALL drop the held instruction; first cycle after release id_ready=1.

Structure
REQ-027 Shared package id_pkg: opcode/funct constants, ALU control codes, ctrl bundle struct.
REQ-028 One sub-module id_regfile (parametrised NREG/XLEN, two read ports, one write port, write-through).

Verification
REQ-029 Reset, R-type add r3=r1+r2 after wb writes r1=5, r2=7 -> next cycle idex_rd1=5, idex_rd2=7, alu_ctrl 0010, dest=3.
REQ-030 lw r4 in EX, next add uses r4 -> id_ready=0 one cycle, one bubble, then add issues.
REQ-031 beq r1,r2 equal, pc4=0x100, imm=0x0003 -> redirect=1, redirect_pc=0x10C; imm=0xFFFF -> 0xFC.
REQ-032 j instr[25:0]=0x40, pc4=0x10000004 -> redirect_pc=0x10000100, idex_valid=0.
REQ-033 wb writes r0=0xFFFF, read r0 -> 0; opcode 111111 -> illegal pulse, bubble.
REQ-034 mem_fwd r5=9 while regfile r5=1 and wb r5=2 -> operand 9.
